btn_event_scheduler: RTL and testbench



---
 rtl/btn_event_scheduler_pkg.sv | 24 ++
 rtl/btn_event_scheduler_channel.sv | 116 +++++++++++
 rtl/btn_event_scheduler.sv | 113 +++++++++++
 tb/tb_btn_event_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_scheduler_pkg.sv
// Shared definitions for the button event scheduler: event type encoding
// and width helpers for ids, queue records and counters.
package btn_event_scheduler_pkg;

  typedef enum logic {
    EVT_PRESS  = 1'b0,
    EVT_REPEAT = 1'b1
  } evt_type_e;

  // Button index width; a single button still needs one id bit.
  function automatic int id_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Queue record is {id, type}.
  function automatic int rec_width(input int n_btn);
    return id_width(n_btn) + 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_event_scheduler_channel.sv
// One button lane: debounce, press edge detect, hold/auto-repeat timer and
// a single pending event slot that merges events arriving while occupied.
module btn_event_scheduler_channel
  import btn_event_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  input  logic grant_i,
  output logic clean_o,
  output logic req_o,
  output logic type_o,
  output logic drop_o
);

  localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              clean_q, clean_d;
  logic              clean_prev_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  evt_type_e         type_q, type_d;
  evt_type_e         new_type;
  logic [HOLD_W-1:0] hold_last;
  logic              press_evt, rpt_evt, new_evt, drop;

  always_comb begin
    db_cnt_d = db_cnt_q;
    clean_d  = clean_q;
    if (!btn_raw_i) begin
      db_cnt_d = '0;
      clean_d  = 1'b0;
    end else if (!clean_q) begin
      db_cnt_d = db_cnt_q + 1'b1;
      if (db_cnt_q == DB_LAST) clean_d = 1'b1;
    end
  end

  // first_q selects the initial hold delay; afterwards the timer reloads at the repeat rate.
  always_comb begin
    press_evt = clean_q & ~clean_prev_q;
    hold_last = first_q ? DELAY_LAST : RATE_LAST;
    rpt_evt   = 1'b0;
    hold_d    = hold_q;
    first_d   = first_q;
    if (!clean_q || !repeat_en_i) begin
      hold_d  = '0;
      first_d = 1'b1;
    end else if (hold_q == hold_last) begin
      rpt_evt = 1'b1;
      hold_d  = '0;
      first_d = 1'b0;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_comb begin
    new_evt = press_evt | rpt_evt;
    if (press_evt) new_type = EVT_PRESS;
    else           new_type = EVT_REPEAT;
    pend_d = pend_q;
    type_d = type_q;
    drop   = 1'b0;
    if (grant_i) begin
      pend_d = new_evt;
      if (new_evt) type_d = new_type;
    end else if (new_evt) begin
      if (pend_q) begin
        drop = 1'b1;
        if (new_type == EVT_PRESS) type_d = EVT_PRESS;
      end else begin
        pend_d = 1'b1;
        type_d = new_type;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q     <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      hold_q       <= '0;
      first_q      <= 1'b1;
      pend_q       <= 1'b0;
      type_q       <= EVT_PRESS;
    end else begin
      db_cnt_q     <= db_cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      hold_q       <= hold_d;
      first_q      <= first_d;
      pend_q       <= pend_d;
      type_q       <= type_d;
    end
  end

  assign clean_o = clean_q;
  assign req_o   = pend_q;
  assign type_o  = type_q;
  assign drop_o  = drop;

endmodule

// File: rtl/btn_event_scheduler.sv
// Button front end: per-button channels feed a fixed-priority arbiter that
// pushes {id, type} records into a small first-word-fall-through queue.
module btn_event_scheduler
  import btn_event_scheduler_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_raw,
  input  logic [N_BTN-1:0]             repeat_en,
  output logic [N_BTN-1:0]             clean_btn,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [id_width(N_BTN)-1:0]   evt_id,
  output logic                         evt_repeat,
  output logic                         evt_dropped
);

  localparam int ID_W  = id_width(N_BTN);
  localparam int REC_W = rec_width(N_BTN);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic [N_BTN-1:0] req, req_type, drop, grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_type;
  logic             push, pop, full;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [REC_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dropped_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_event_scheduler_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_i   (btn_raw[gi]),
        .repeat_en_i (repeat_en[gi]),
        .grant_i     (grant[gi]),
        .clean_o     (clean_btn[gi]),
        .req_o       (req[gi]),
        .type_o      (req_type[gi]),
        .drop_o      (drop[gi])
      );
    end
  endgenerate

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    grant      = '0;
    grant_id   = '0;
    grant_type = 1'b0;
    push       = 1'b0;
    if (!full) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (req[i] && !push) begin
          push       = 1'b1;
          grant[i]   = 1'b1;
          grant_id   = ID_W'(i);
          grant_type = req_type[i];
        end
      end
    end
  end

  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grant_id, grant_type};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= |drop;
    end
  end

  assign evt_id      = evt_valid ? head[REC_W-1:1] : '0;
  assign evt_repeat  = evt_valid & head[0];
  assign evt_dropped = dropped_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Scoreboard bench for btn_event_scheduler: expected {id, type} records are
// queued as buttons are driven and compared as the consumer accepts events.
module tb_btn_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw, repeat_en, clean_btn;
  logic       evt_valid, evt_ready, evt_repeat, evt_dropped;
  logic [2:0] evt_id;

  always #5 clk = ~clk;

  btn_event_scheduler #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .clean_btn(clean_btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_repeat(evt_repeat), .evt_dropped(evt_dropped)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  int pop_cyc[$];
  int cyc = 0;
  int drop_cnt = 0;
  int valid_cnt = 0;
  int drop0;
  logic [4:0] clean_acc = '0;
  logic       stall_q = 1'b0;
  logic [2:0] stall_id;
  logic       stall_rep;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ev(input int id, input int rep);
    return id * 2 + rep;
  endfunction

  // Consumer-side monitor: one line per accepted event.
  always @(negedge clk) begin
    int exp_v;
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (evt_dropped) drop_cnt++;
      if (evt_valid) valid_cnt++;
      clean_acc = clean_acc | clean_btn;
      if (stall_q && evt_valid) begin
        chk("stall_id", int'(evt_id), int'(stall_id));
        chk("stall_rep", int'(evt_repeat), int'(stall_rep));
      end
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_evt", int'({evt_id, evt_repeat}), -1);
        end else begin
          exp_v = sb.pop_front();
          $display("evt cyc=%0d id=%0d repeat=%0d (exp id=%0d repeat=%0d)",
                   cyc, evt_id, evt_repeat, exp_v / 2, exp_v % 2);
          chk("evt", int'({evt_id, evt_repeat}), exp_v);
          pop_cyc.push_back(cyc);
        end
      end
      stall_q   = evt_valid && !evt_ready;
      stall_id  = evt_id;
      stall_rep = evt_repeat;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || evt_valid) && k < 400) begin
      tick();
      k++;
    end
    tick(10);
    chk(tag, sb.size(), 0);
    chk({tag, "_idle"}, int'(evt_valid), 0);
  endtask

  initial begin
    rst = 1'b1; btn_raw = '0; repeat_en = '0; evt_ready = 1'b0;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_repeat", int'(evt_repeat), 0);
    chk("rst_dropped", int'(evt_dropped), 0);
    chk("rst_clean", int'(clean_btn), 0);
    rst = 1'b0;
    tick(2);

    // Glitches shorter than the debounce window.
    clean_acc = '0; valid_cnt = 0;
    repeat (5) begin
      btn_raw[2] = 1'b1; tick(3);
      btn_raw[2] = 1'b0; tick(2);
    end
    tick(5);
    chk("glitch_clean", int'(clean_acc), 0);
    chk("glitch_valid", valid_cnt, 0);

    // Clean press, latency, silent release.
    evt_ready = 1'b1;
    sb.push_back(ev(2, 0));
    btn_raw[2] = 1'b1;
    tick(3); chk("db_not_yet", int'(clean_btn[2]), 0);
    tick(1); chk("db_rise", int'(clean_btn[2]), 1);
    tick(1); chk("lat_edge1", int'(evt_valid), 0);
    tick(1); chk("lat_edge2", int'(evt_valid), 1);
    tick(10);
    btn_raw[2] = 1'b0;
    drain("press_drain");

    // Simultaneous press: priority order, back-to-back.
    pop_cyc.delete();
    sb.push_back(ev(1, 0)); sb.push_back(ev(4, 0));
    btn_raw[4] = 1'b1; btn_raw[1] = 1'b1;
    tick(12);
    btn_raw = '0;
    drain("simul_drain");
    chk("simul_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) chk("simul_gap", pop_cyc[1] - pop_cyc[0], 1);

    // Auto-repeat on a 60-cycle hold.
    repeat_en[0] = 1'b1;
    pop_cyc.delete();
    sb.push_back(ev(0, 0));
    repeat (5) sb.push_back(ev(0, 1));
    btn_raw[0] = 1'b1;
    tick(60);
    btn_raw[0] = 1'b0;
    drain("repeat_drain");
    chk("repeat_pops", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) begin
      chk("repeat_first_gap", pop_cyc[1] - pop_cyc[0], 19);
      for (int k = 2; k < 6; k++) chk("repeat_gap", pop_cyc[k] - pop_cyc[k-1], 8);
    end

    repeat_en[0] = 1'b0;
    sb.push_back(ev(0, 0));
    btn_raw[0] = 1'b1;
    tick(60);
    btn_raw[0] = 1'b0;
    drain("norepeat_drain");

    // Backpressure: queue fills with 0..3, button 4 waits pending.
    evt_ready = 1'b0;
    drop0 = drop_cnt;
    for (int k = 0; k < 5; k++) sb.push_back(ev(k, 0));
    btn_raw = 5'h1F;
    tick(12);
    chk("full_valid", int'(evt_valid), 1);
    chk("full_head", int'(evt_id), 0);
    btn_raw[0] = 1'b0;
    tick(2);
    sb.push_back(ev(0, 0));
    evt_ready = 1'b1;
    btn_raw[0] = 1'b1;
    tick(12);
    btn_raw = '0;
    drain("bp_drain");
    chk("bp_no_drop", drop_cnt - drop0, 0);

    // Merge: button 0 pends behind a full queue, then is pressed again.
    evt_ready = 1'b0;
    drop0 = drop_cnt;
    for (int k = 1; k < 5; k++) sb.push_back(ev(k, 0));
    btn_raw = 5'h1E;
    tick(12);
    sb.push_back(ev(0, 0));
    btn_raw[0] = 1'b1;
    tick(8);
    chk("merge_pre_drop", drop_cnt - drop0, 0);
    btn_raw[0] = 1'b0;
    tick(2);
    btn_raw[0] = 1'b1;
    tick(8);
    chk("merge_drop", drop_cnt - drop0, 1);
    evt_ready = 1'b1;
    tick(2);
    btn_raw = '0;
    drain("merge_drain");
    chk("merge_drop_once", drop_cnt - drop0, 1);

    // Reset while button 3 is held and two events are queued.
    evt_ready = 1'b0;
    sb.push_back(ev(2, 0)); sb.push_back(ev(3, 0));
    btn_raw[2] = 1'b1; btn_raw[3] = 1'b1;
    tick(10);
    btn_raw[2] = 1'b0;
    tick(2);
    chk("pre_rst_valid", int'(evt_valid), 1);
    rst = 1'b1;
    sb.delete();
    tick(1);
    rst = 1'b0;
    chk("post_rst_valid", int'(evt_valid), 0);
    chk("post_rst_clean", int'(clean_btn[3]), 0);
    tick(3); chk("rst_db_not_yet", int'(clean_btn[3]), 0);
    tick(1); chk("rst_db_rise", int'(clean_btn[3]), 1);
    sb.push_back(ev(3, 0));
    evt_ready = 1'b1;
    tick(6);
    btn_raw = '0;
    drain("rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
